// File: rtl/axi_slave_rd_resp_fsm_pkg.sv
// Shared types for the AXI slave read-response path: response codes, FSM states
// and small helpers used by the R-channel transmitter.
package axi_slave_rd_resp_fsm_pkg;

    localparam int RRESP_WIDTH = 2;

    typedef enum logic [RRESP_WIDTH-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_resp_state_t;

    // SLVERR and DECERR share the upper bit; OKAY/EXOKAY both carry real data.
    function automatic logic resp_is_err(input logic [RRESP_WIDTH-1:0] resp);
        return resp[1];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/axi_slave_rd_resp_fsm_if.sv
// Completion-header, data-FIFO and AXI R-channel bundle for the read-response
// transmitter; slave modport faces the design, master modport faces its environment.
interface axi_slave_rd_resp_fsm_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 8
);
    logic                  hdr_valid;
    logic                  hdr_ready;
    logic [ID_WIDTH-1:0]   hdr_id;
    logic [LEN_WIDTH-1:0]  hdr_len;
    logic [1:0]            hdr_resp;

    logic                  dat_empty;
    logic [DATA_WIDTH-1:0] dat_rdata;
    logic                  dat_rd_en;

    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  hdr_valid, hdr_id, hdr_len, hdr_resp,
        input  dat_empty, dat_rdata, RREADY,
        output hdr_ready, dat_rd_en,
        output RID, RDATA, RRESP, RLAST, RVALID
    );

    modport master (
        output hdr_valid, hdr_id, hdr_len, hdr_resp,
        output dat_empty, dat_rdata, RREADY,
        input  hdr_ready, dat_rd_en,
        input  RID, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/axi_slave_rd_resp_fsm_r_out_reg.sv
// R-channel holding register: loads a beat when told to, drops RVALID once the
// master accepts and nothing new is loaded, and holds its payload while stalled.
module axi_r_out_reg #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  ready,
    input  logic [ID_WIDTH-1:0]   id_d,
    input  logic [DATA_WIDTH-1:0] data_d,
    input  logic [1:0]            resp_d,
    input  logic                  last_d,
    output logic                  valid,
    output logic [ID_WIDTH-1:0]   id,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            resp,
    output logic                  last
);

    logic                  vld_p1;
    logic [ID_WIDTH-1:0]   id_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [1:0]            resp_p1;
    logic                  last_p1;

    // Stage p1: registered R-channel beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            id_p1   <= '0;
            data_p1 <= '0;
            resp_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            id_p1   <= id_d;
            data_p1 <= data_d;
            resp_p1 <= resp_d;
            last_p1 <= last_d;
        end else if (vld_p1 && ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign valid = vld_p1;
    assign id    = id_p1;
    assign data  = data_p1;
    assign resp  = resp_p1;
    assign last  = last_p1;

endmodule

// File: rtl/axi_slave_rd_resp_fsm.sv
// AXI slave read-response transmitter: turns completion headers plus FWFT data
// beats into R-channel bursts. Optional AXI_SLAVE_R_ERR_CNT_EN adds err_cnt.
module axi_slave_rd_resp_fsm
    import axi_slave_rd_resp_fsm_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    axi_slave_rd_resp_fsm_if.slave bus
`ifdef AXI_SLAVE_R_ERR_CNT_EN
    ,
    output logic [15:0]            err_cnt
`endif
);

    rd_resp_state_t        state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [1:0]            resp_q;
    logic                  err_q;
    logic [LEN_WIDTH-1:0]  beat_cnt_q;

    logic                  hdr_ready_c;
    logic                  hdr_take;
    logic                  load_c;
    logic                  out_free;
    logic                  beat_avail;
    logic                  last_beat;

    logic                  rvalid;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    assign out_free   = !rvalid || bus.RREADY;
    assign beat_avail = err_q || !bus.dat_empty;
    // Compare before the increment so a full-length burst ends at cnt == len.
    assign last_beat  = (beat_cnt_q == len_q);
    assign hdr_take   = bus.hdr_valid && hdr_ready_c;

    always_comb begin
        state_d     = state_q;
        hdr_ready_c = 1'b0;
        load_c      = 1'b0;
        case (state_q)
            IDLE: begin
                hdr_ready_c = ARESETn && out_free;
                if (bus.hdr_valid && hdr_ready_c) state_d = BURST;
            end
            BURST: begin
                load_c = beat_avail && out_free;
                if (load_c && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Stage p0: header capture and beat counting
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q       <= '0;
            len_q      <= '0;
            resp_q     <= '0;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
        end else if (hdr_take) begin
            id_q       <= bus.hdr_id;
            len_q      <= bus.hdr_len;
            resp_q     <= bus.hdr_resp;
            err_q      <= resp_is_err(bus.hdr_resp);
            beat_cnt_q <= '0;
        end else if (load_c) begin
            beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
        end
    end

    axi_r_out_reg #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk    (ACLK),
        .rst_n  (ARESETn),
        .load   (load_c),
        .ready  (bus.RREADY),
        .id_d   (id_q),
        .data_d (err_q ? '0 : bus.dat_rdata),
        .resp_d (resp_q),
        .last_d (last_beat),
        .valid  (rvalid),
        .id     (rid),
        .data   (rdata),
        .resp   (rresp),
        .last   (rlast)
    );

    assign bus.hdr_ready = hdr_ready_c;
    // Error beats are synthesized locally, so they never consume FIFO data.
    assign bus.dat_rd_en = load_c && !err_q;
    assign bus.RVALID    = rvalid;
    assign bus.RID       = rid;
    assign bus.RDATA     = rdata;
    assign bus.RRESP     = rresp;
    assign bus.RLAST     = rlast;

`ifdef AXI_SLAVE_R_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            err_cnt_q <= '0;
        else if (rvalid && bus.RREADY && rlast && resp_is_err(rresp))
            err_cnt_q <= sat_inc16(err_cnt_q);
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_slave_rd_resp_fsm.sv
// Self-checking bench for axi_slave_rd_resp_fsm: table of burst scenarios driven
// through a FIFO model, with expected R beats kept in a scoreboard queue.
module tb_axi_slave_rd_resp_fsm;
    localparam int ID_WIDTH   = 4;
    localparam int DATA_WIDTH = 256;
    localparam int LEN_WIDTH  = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef struct {
        logic [ID_WIDTH-1:0] id;
        data_t               data;
        logic [1:0]          resp;
        logic                last;
    } beat_t;
    typedef struct {
        logic [ID_WIDTH-1:0]  id;
        logic [LEN_WIDTH-1:0] len;
        logic [1:0]           resp;
    } hdr_t;
    typedef struct {
        string name;
        hdr_t  h0;
        bit    two;
        hdr_t  h1;
        int    rready_mode;
        bit    gap;
        int    exp_beats;
        int    exp_pops;
        int    exp_lat;
    } vec_t;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_slave_rd_resp_fsm_if #(.ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

`ifdef AXI_SLAVE_R_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    axi_slave_rd_resp_fsm #(.ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .ARESETn (ARESETn),
        .ACLK    (ACLK),
        .bus     (bus)
`ifdef AXI_SLAVE_R_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    int    tests = 0;
    int    fails = 0;
    beat_t exp_q[$];
    data_t fifo_q[$];
    data_t ref_q[$];
    hdr_t  hq[$];
    int    cyc = 0;
    int    beats, pops, gap_cnt, rready_mode, hdr_cyc, first_cyc, err_bursts;
    bit    gap_en, saw_gap_low, prev_stall;
    beat_t prev_beat;
    vec_t  vecs[8];

    task automatic check(input string nm, input logic [DATA_WIDTH-1:0] act, input logic [DATA_WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input hdr_t h0, input bit two, input hdr_t h1,
                                input int rm, input bit gap, input int eb, input int ep, input int el);
        vec_t v;
        v.name = nm; v.h0 = h0; v.two = two; v.h1 = h1; v.rready_mode = rm;
        v.gap = gap; v.exp_beats = eb; v.exp_pops = ep; v.exp_lat = el;
        return v;
    endfunction

    function automatic hdr_t hd(input int id, input int len, input logic [1:0] resp);
        hdr_t h;
        h.id = ID_WIDTH'(id); h.len = LEN_WIDTH'(len); h.resp = resp;
        return h;
    endfunction

    task automatic drive();
        bus.hdr_valid = (hq.size() > 0);
        bus.hdr_id    = (hq.size() > 0) ? hq[0].id   : '0;
        bus.hdr_len   = (hq.size() > 0) ? hq[0].len  : '0;
        bus.hdr_resp  = (hq.size() > 0) ? hq[0].resp : '0;
        bus.dat_empty = (fifo_q.size() == 0) || (gap_cnt > 0);
        bus.dat_rdata = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        bus.RREADY    = (rready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    endtask

    task automatic enqueue_hdr(input hdr_t h);
        data_t w;
        hq.push_back(h);
        if (!h.resp[1]) begin
            for (int i = 0; i <= int'(h.len); i++) begin
                for (int k = 0; k < DATA_WIDTH / 32; k++) w[k*32 +: 32] = $urandom;
                fifo_q.push_back(w);
                ref_q.push_back(w);
            end
        end
    endtask

    // One clock: observe at the falling edge, update the FIFO model after the rising edge.
    task automatic step();
        bit    popd;
        hdr_t  h;
        beat_t b;
        beat_t e;
        @(negedge ACLK);
        popd = 1'b0;
        if (prev_stall) begin
            check("stall_rvalid", bus.RVALID, 1'b1);
            check("stall_rid",    bus.RID,    prev_beat.id);
            check("stall_rdata",  bus.RDATA,  prev_beat.data);
            check("stall_rresp",  bus.RRESP,  prev_beat.resp);
            check("stall_rlast",  bus.RLAST,  prev_beat.last);
        end
        if (bus.RVALID && !bus.RREADY) check("pop_in_stall", bus.dat_rd_en, 1'b0);
        if (bus.dat_rd_en) begin
            check("pop_when_empty", bus.dat_empty, 1'b0);
            popd = 1'b1;
            pops++;
        end
        if (bus.RVALID && first_cyc < 0) first_cyc = cyc;
        if (gap_cnt > 0 && !bus.RVALID) saw_gap_low = 1'b1;
        if (bus.hdr_ready)
            check("hdr_ready_early",
                  (exp_q.size() == 0) || (exp_q.size() == 1 && bus.RVALID && bus.RREADY), 1'b1);
        if (bus.RVALID && bus.RREADY) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("rid",   bus.RID,   e.id);
                check("rdata", bus.RDATA, e.data);
                check("rresp", bus.RRESP, e.resp);
                check("rlast", bus.RLAST, e.last);
                beats++;
                if (e.last && e.resp[1]) err_bursts++;
            end
        end
        if (bus.hdr_valid && bus.hdr_ready) begin
            h = hq.pop_front();
            if (hdr_cyc < 0) hdr_cyc = cyc;
            for (int i = 0; i <= int'(h.len); i++) begin
                b.id   = h.id;
                b.resp = h.resp;
                b.last = (i == int'(h.len));
                b.data = h.resp[1] ? '0 : ref_q.pop_front();
                exp_q.push_back(b);
            end
        end
        prev_stall     = bus.RVALID && !bus.RREADY;
        prev_beat.id   = bus.RID;
        prev_beat.data = bus.RDATA;
        prev_beat.resp = bus.RRESP;
        prev_beat.last = bus.RLAST;
        @(posedge ACLK);
        #1;
        if (popd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (gap_cnt > 0) gap_cnt--;
        if (gap_en && popd && pops == 1) gap_cnt = 3;
        cyc++;
        drive();
    endtask

    task automatic run_vec(input vec_t v);
        bit done;
        beats = 0; pops = 0; gap_cnt = 0; hdr_cyc = -1; first_cyc = -1;
        gap_en = v.gap; saw_gap_low = 1'b0; rready_mode = v.rready_mode;
        enqueue_hdr(v.h0);
        if (v.two) enqueue_hdr(v.h1);
        drive();
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            step();
            done = (hq.size() == 0) && (exp_q.size() == 0);
        end
        check({v.name, "/timeout"}, done, 1'b1);
        check({v.name, "/beats"}, beats, v.exp_beats);
        check({v.name, "/pops"},  pops,  v.exp_pops);
        check({v.name, "/fifo_drained"}, fifo_q.size(), 0);
        if (v.exp_lat > 0) check({v.name, "/latency"}, first_cyc - hdr_cyc, v.exp_lat);
        if (v.gap) check({v.name, "/gap_bubble"}, saw_gap_low, 1'b1);
        rready_mode = 0;
        drive();
        step();
        step();
        check({v.name, "/idle_rvalid"}, bus.RVALID, 1'b0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "/rvalid"},    bus.RVALID,    1'b0);
        check({nm, "/rlast"},     bus.RLAST,     1'b0);
        check({nm, "/rid"},       bus.RID,       '0);
        check({nm, "/rdata"},     bus.RDATA,     '0);
        check({nm, "/rresp"},     bus.RRESP,     '0);
        check({nm, "/hdr_ready"}, bus.hdr_ready, 1'b0);
        check({nm, "/dat_rd_en"}, bus.dat_rd_en, 1'b0);
    endtask

    initial begin
        vecs[0] = mk("okay_len3",   hd(1, 3, 2'b00),   1'b0, hd(0, 0, 2'b00), 0, 1'b0, 4,   4,   2);
        vecs[1] = mk("slverr_len1", hd(2, 1, 2'b10),   1'b0, hd(0, 0, 2'b00), 0, 1'b0, 2,   0,   2);
        vecs[2] = mk("stall_len2",  hd(3, 2, 2'b00),   1'b0, hd(0, 0, 2'b00), 1, 1'b0, 3,   3,   0);
        vecs[3] = mk("gap_len2",    hd(4, 2, 2'b00),   1'b0, hd(0, 0, 2'b00), 0, 1'b1, 3,   3,   2);
        vecs[4] = mk("b2b",         hd(5, 0, 2'b00),   1'b1, hd(6, 1, 2'b00), 0, 1'b0, 3,   3,   2);
        vecs[5] = mk("exokay_len0", hd(7, 0, 2'b01),   1'b0, hd(0, 0, 2'b00), 0, 1'b0, 1,   1,   2);
        vecs[6] = mk("decerr_len0", hd(8, 0, 2'b11),   1'b0, hd(0, 0, 2'b00), 0, 1'b0, 1,   0,   2);
        vecs[7] = mk("okay_len255", hd(9, 255, 2'b00), 1'b0, hd(0, 0, 2'b00), 0, 1'b0, 256, 256, 2);

        err_bursts = 0; gap_cnt = 0; rready_mode = 0; prev_stall = 1'b0;
        beats = 0; pops = 0; hdr_cyc = -1; first_cyc = -1;
        ARESETn = 1'b0;
        drive();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_all_zero("reset");
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        drive();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

`ifdef AXI_SLAVE_R_ERR_CNT_EN
        check("err_cnt", err_cnt, 16'(err_bursts));
`endif

        // Reset while beat 2 of a len=7 burst is on the bus.
        beats = 0; pops = 0; rready_mode = 0;
        enqueue_hdr(hd(3, 7, 2'b00));
        drive();
        for (int c = 0; c < 50 && beats < 1; c++) step();
        check("midreset/reached_beat2", bus.RVALID && bus.RID == 4'd3, 1'b1);
        #2;
        ARESETn = 1'b0;
        #1;
        check_all_zero("midreset");
        hq.delete(); exp_q.delete(); fifo_q.delete(); ref_q.delete();
        prev_stall = 1'b0; gap_cnt = 0; err_bursts = 0;
        drive();
        @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        drive();
        run_vec(mk("after_reset", hd(1, 0, 2'b00), 1'b0, hd(0, 0, 2'b00), 0, 1'b0, 1, 1, 2));

`ifdef AXI_SLAVE_R_ERR_CNT_EN
        check("err_cnt_after_reset", err_cnt, 16'(err_bursts));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_slave_rd_resp_fsm.md
Name: axi_slave_rd_resp_fsm

Overview:
- AXI slave read-response transmitter; the R-channel counterpart of the slave request push FSMs.
- Accepts one completed read burst header at a time from the completion side and pops payload beats from a first-word-fall-through (FWFT) data FIFO.
- Drives RID/RDATA/RRESP/RLAST/RVALID toward the AXI master and honours RREADY back-pressure.
- Error responses (SLVERR/DECERR) are synthesized locally with zero data and no FIFO pops.

Parameters:
- ID_WIDTH, 4, width of RID/hdr_id; equals $clog2(ARFIFO_DEPTH).
- DATA_WIDTH, 256, RDATA width in bits; equals AXI_MAX_NUM_BYTES*8.
- LEN_WIDTH, 8, burst length field width, beats-1; equals $clog2(AXI_MAX_NUM_TRANSFERS).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous, active-low reset.
- hdr_valid  in  1  completion header available.
- hdr_ready  out  1  header accepted this cycle.
- hdr_id  in  ID_WIDTH  transaction ID.
- hdr_len  in  LEN_WIDTH  beats-1.
- hdr_resp  in  2  response code.
- dat_empty  in  1  data FIFO empty.
- dat_rdata  in  DATA_WIDTH  FWFT head of data FIFO.
- dat_rd_en  out  1  pop data FIFO.
- RID  out  ID_WIDTH  read ID.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RLAST  out  1  last beat of burst.
- RVALID  out  1  beat valid.
- RREADY  in  1  master ready.

Behaviour:
- Reset (asynchronous, ARESETn low): state=IDLE, beat_cnt=0, hdr_ready=0, dat_rd_en=0, RVALID=0, RLAST=0, RID/RDATA/RRESP=0. Reset mid-burst abandons the burst; the FIFO is reset alongside.
- FSM states are IDLE and BURST.
- IDLE:
  - hdr_ready is combinational: 1 when state=IDLE and the output register is free (RVALID=0, or RVALID&RREADY).
  - On hdr_valid&hdr_ready: latch id/len/resp, set err = hdr_resp[1], beat_cnt=0, go to BURST.
- BURST:
  - A beat is available when err=1 or dat_empty=0.
  - Load condition: beat available AND (RVALID=0 OR RREADY=1).
  - On load: RVALID<=1, RID<=id, RRESP<=resp, RDATA<=err?0:dat_rdata, RLAST<=(beat_cnt==len), dat_rd_en=!err (combinational, same cycle), beat_cnt++.
  - If the loaded beat is last, go to IDLE.
- Unload: if RVALID&RREADY and no load occurs, RVALID<=0.
- AXI stability: while RVALID=1 and RREADY=0, RID/RDATA/RRESP/RLAST hold and no pop occurs.
- Timing:
  - Latency: header accepted in cycle N; first RVALID at N+2 at the earliest.
  - Steady state: 1 beat/cycle with RREADY held high.
  - Back-to-back bursts: IDLE accepts the next header in the same cycle the last beat is handed off; the next burst's first beat lands no earlier than 2 cycles later.
- Boundaries:
  - dat_empty mid-burst: a bubble is allowed; RVALID drops after the pending beat is accepted and no spurious beat is issued.
  - len=0: single beat with RLAST=1.
  - len=2^LEN_WIDTH-1: beat_cnt must not wrap before the compare.
  - hdr_valid during BURST: ignored, hdr_ready=0.
  - EXOKAY (01): treated as OKAY-class, data is popped.
- dat_rd_en is never asserted while dat_empty=1.

Optional Feature:
- Macro AXI_SLAVE_R_ERR_CNT_EN.
- With the macro defined: adds output err_cnt[15:0], a saturating count of bursts whose RRESP was SLVERR/DECERR. It increments when the RLAST beat handshakes, saturates at 16'hFFFF, and resets to 0.
- Without the macro: the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- axi_slave_package gains:
  - RRESP_WIDTH=2.
  - enum resp_t {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}.
  - enum rd_resp_state_t {IDLE, BURST}.
- axi_if gains R-channel signals and matching slave/tb modports.
- One sub-module, axi_r_out_reg: the RVALID/RREADY holding register with load/unload logic. The FSM and beat counter stay in the top module.

Test Plan:
- OKAY, len=3, FIFO holds D0..D3, RREADY=1: 4 beats D0..D3 on consecutive cycles; RLAST only on D3; 4 pops; first RVALID 2 cycles after the hdr handshake.
- SLVERR, len=1: 2 beats, RDATA=0, RRESP=2'b10, RLAST on the 2nd beat; dat_rd_en never asserted; err_cnt=1 with the macro.
- OKAY, len=2, RREADY toggling 1,0,0,1,...: outputs stable while stalled; exactly 3 pops; no pop while RVALID&!RREADY.
- OKAY, len=2 with dat_empty=1 for 3 cycles after the 1st beat: RVALID deasserts during the gap; resumes with the correct 2nd/3rd beats; no duplicate beats.
- Two headers presented back-to-back (id=5 len=0, id=6 len=1): hdr_ready=0 during the first burst; 3 beats total, RID=5,6,6.
- ARESETn pulsed low during beat 2 of a len=7 burst: all outputs 0 immediately; after release, a new header (id=1 len=0) completes normally.
